// File: rtl/ir_rc5_transmitter.sv
// RC5 IR transmitter: serialises {1,1,toggle,address[4:0],command[5:0]} as Manchester half-bits, then idles for the gap.
// Optional carrier modulation of IrOut is enabled by defining IR_TX_CARRIER_EN.
module ir_rc5_transmitter #(
  parameter int HALF_BIT_CYCLES     = 22225,
  parameter int GAP_HALF_BITS       = 228,
  parameter int CARRIER_HALF_CYCLES = 347
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Send,
  input  logic [4:0] Address,
  input  logic [5:0] Command,
  input  logic       Repeat,
  output logic       Ready,
  output logic       Busy,
  output logic       IrOut,
  output logic [1:0] dbg_state
);

  localparam int HW = $clog2(HALF_BIT_CYCLES);
  localparam int GW = (GAP_HALF_BITS > 1) ? $clog2(GAP_HALF_BITS) : 1;

  // Handshake: a request transfers on a rising edge where Send && Ready; Send while Ready=0 is dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  if (HALF_BIT_CYCLES < 2) begin : g_bad_half_bit
    $error("HALF_BIT_CYCLES must be at least 2");
  end
  if (GAP_HALF_BITS < 1 || CARRIER_HALF_CYCLES < 1) begin : g_bad_gap_carrier
    $error("GAP_HALF_BITS and CARRIER_HALF_CYCLES must be at least 1");
  end

  state_t          state_q, state_d;
  logic [13:0]     frame_q, frame_d;
  logic            toggle_q, toggle_d;
  logic [HW-1:0]   hb_cnt_q, hb_cnt_d;
  logic [4:0]      hb_idx_q, hb_idx_d;
  logic [GW-1:0]   gap_idx_q, gap_idx_d;
  logic            ready_q, ready_d;
  logic            ir_q, ir_d;
  logic            env_d;
  logic            bit_sel;
  logic            hb_last;

`ifdef IR_TX_CARRIER_EN
  localparam int CW = (CARRIER_HALF_CYCLES > 1) ? $clog2(CARRIER_HALF_CYCLES) : 1;
  logic [CW-1:0]   car_cnt_q, car_cnt_d;
  logic            car_ph_q, car_ph_d;
`endif

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    toggle_d  = toggle_q;
    hb_cnt_d  = hb_cnt_q;
    hb_idx_d  = hb_idx_q;
    gap_idx_d = gap_idx_q;
    env_d     = 1'b0;
    bit_sel   = 1'b0;
    hb_last   = (hb_cnt_q == HW'(HALF_BIT_CYCLES - 1));

    case (state_q)
      IDLE: begin
        hb_cnt_d  = '0;
        hb_idx_d  = '0;
        gap_idx_d = '0;
        if (Send) begin
          toggle_d = Repeat ? toggle_q : ~toggle_q;
          frame_d  = {2'b11, toggle_d, Address, Command};
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hb_last) begin
          hb_cnt_d = '0;
          if (hb_idx_q == 5'd27) begin
            hb_idx_d = '0;
            state_d  = GAP;
          end else begin
            hb_idx_d = hb_idx_q + 5'd1;
          end
        end else begin
          hb_cnt_d = hb_cnt_q + HW'(1);
        end
      end
      GAP: begin
        if (hb_last) begin
          hb_cnt_d = '0;
          if (gap_idx_q == GW'(GAP_HALF_BITS - 1)) begin
            gap_idx_d = '0;
            state_d   = IDLE;
          end else begin
            gap_idx_d = gap_idx_q + GW'(1);
          end
        end else begin
          hb_cnt_d = hb_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Envelope is computed for the next cycle so IrOut leaves a flop with no input-to-output path.
    if (state_d == SEND) begin
      bit_sel = frame_d[4'd13 - hb_idx_d[4:1]];
      env_d   = hb_idx_d[0] ? bit_sel : ~bit_sel;
    end

    ready_d = (state_d == IDLE);

`ifdef IR_TX_CARRIER_EN
    car_cnt_d = '0;
    car_ph_d  = 1'b0;
    if (state_q == IDLE && Send) begin
      car_ph_d = 1'b1;
    end else if (state_d == SEND) begin
      if (car_cnt_q == CW'(CARRIER_HALF_CYCLES - 1)) begin
        car_ph_d = ~car_ph_q;
      end else begin
        car_cnt_d = car_cnt_q + CW'(1);
        car_ph_d  = car_ph_q;
      end
    end
    ir_d = env_d & car_ph_d;
`else
    ir_d = env_d;
`endif
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      toggle_q  <= 1'b0;
      hb_cnt_q  <= '0;
      hb_idx_q  <= '0;
      gap_idx_q <= '0;
      ready_q   <= 1'b1;
      ir_q      <= 1'b0;
`ifdef IR_TX_CARRIER_EN
      car_cnt_q <= '0;
      car_ph_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      toggle_q  <= toggle_d;
      hb_cnt_q  <= hb_cnt_d;
      hb_idx_q  <= hb_idx_d;
      gap_idx_q <= gap_idx_d;
      ready_q   <= ready_d;
      ir_q      <= ir_d;
`ifdef IR_TX_CARRIER_EN
      car_cnt_q <= car_cnt_d;
      car_ph_q  <= car_ph_d;
`endif
    end
  end

  assign Ready     = ready_q;
  assign Busy      = ~ready_q;
  assign IrOut     = ir_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ir_rc5_transmitter.sv
// Self-checking bench for ir_rc5_transmitter: directed scenarios with random address/command,
// compared cycle by cycle against a Manchester waveform model built from the frame bits.
module tb_ir_rc5_transmitter;

  localparam int H = 4;
  localparam int G = 6;
  localparam int C = 1;
  localparam int FRAME_CYC = 28 * H;
  localparam int BUSY_CYC  = (28 + G) * H;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [4:0] address = '0;
  logic [5:0] command = '0;
  logic       repeat_in = 1'b0;
  logic       ready;
  logic       busy;
  logic       ir_out;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ir_rc5_transmitter #(
    .HALF_BIT_CYCLES    (H),
    .GAP_HALF_BITS      (G),
    .CARRIER_HALF_CYCLES(C)
  ) dut (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .Send     (send),
    .Address  (address),
    .Command  (command),
    .Repeat   (repeat_in),
    .Ready    (ready),
    .Busy     (busy),
    .IrOut    (ir_out),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [0:0]  exp_q[$];
  bit          model_toggle = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected IrOut for every busy cycle after an accept: 28 Manchester half-bits then the silent gap.
  task automatic build_expected(input logic [4:0] a, input logic [5:0] c, input bit t);
    logic [13:0] frame;
    logic        b;
    logic        env;
    int          h;
    frame = {2'b11, t, a, c};
    exp_q.delete();
    for (int k = 0; k < BUSY_CYC; k++) begin
      if (k < FRAME_CYC) begin
        h   = k / H;
        b   = frame[13 - h / 2];
        env = (h % 2 == 1) ? b : ~b;
`ifdef IR_TX_CARRIER_EN
        env = env & ((k / C) % 2 == 0);
`endif
      end else begin
        env = 1'b0;
      end
      exp_q.push_back(env);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    send  = 1'b0;
    #1;
    chk("reset_ready", ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_irout", ir_out, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_toggle = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where Ready is back high.
  task automatic do_frame(input logic [4:0] a, input logic [5:0] c, input bit rep,
                          input bit hold, input bit pulse);
    address   = a;
    command   = c;
    repeat_in = rep;
    send      = 1'b1;
    chk("ready_before_accept", ready, 1'b1);
    if (!rep) model_toggle = ~model_toggle;
    build_expected(a, c, model_toggle);
    @(posedge clk);
    #1;
    if (!hold) send = 1'b0;
    for (int k = 0; k < BUSY_CYC; k++) begin
      @(negedge clk);
      if (pulse && !hold && (k == 50 || k == 120)) begin
        address   = 5'($urandom);
        command   = 6'($urandom);
        repeat_in = 1'($urandom);
        send      = 1'b1;
      end else if (!hold) begin
        send = 1'b0;
      end
      chk($sformatf("irout k=%0d", k), ir_out, exp_q.pop_front());
      chk($sformatf("ready_low k=%0d", k), ready, 1'b0);
      chk($sformatf("busy_high k=%0d", k), busy, 1'b1);
    end
    @(negedge clk);
    chk("ready_after_gap", ready, 1'b1);
    chk("busy_after_gap", busy, 1'b0);
    chk("irout_idle", ir_out, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] a;
    logic [5:0] c;

    do_reset();
    do_frame(5'b01101, 6'd1, 1'b0, 1'b0, 1'b0);

    // Send held high: each next frame is accepted in the single IDLE cycle after the gap.
    do_reset();
    do_frame(5'($urandom), 6'($urandom), 1'b0, 1'b1, 1'b0);
    do_frame(5'($urandom), 6'($urandom), 1'b1, 1'b1, 1'b0);
    do_frame(5'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0);

    do_frame(5'($urandom), 6'($urandom), 1'($urandom), 1'b0, 1'b1);

    // Asynchronous reset during half-bit 9, which carries address bit 3 as a mark.
    a = 5'($urandom) | 5'b01000;
    c = 6'($urandom);
    address   = a;
    command   = c;
    repeat_in = 1'b0;
    send      = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
    repeat (37) @(posedge clk);
    #2;
`ifndef IR_TX_CARRIER_EN
    chk("pre_reset_mark", ir_out, 1'b1);
`endif
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_irout", ir_out, 1'b0);
    chk("async_ready", ready, 1'b1);
    chk("async_busy", busy, 1'b0);
    model_toggle = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(5'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0);

    do_reset();
    do_frame(5'b11111, 6'b111111, 1'b0, 1'b0, 1'b0);

    do_reset();
    do_frame(5'($urandom), 6'($urandom), 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      do_frame(5'($urandom), 6'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
